// File: rtl/shift_arbiter.sv
// Two-requester front end for a shared combinational shifter: grant in IDLE, capture in EXEC, hold the result in RESP until consumed.
// SHIFT_ARB_RR_EN selects round-robin arbitration; otherwise requester 0 has fixed priority.
module shift_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [15:0] req0_data,
  input  logic [15:0] req1_data,
  input  logic [3:0]  req0_amt,
  input  logic [3:0]  req1_amt,
  input  logic        req0_mode,
  input  logic        req1_mode,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [15:0] rsp_data,
  output logic [15:0] shf_in,
  output logic [3:0]  shf_val,
  output logic        shf_mode,
  input  logic [15:0] shf_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  amt_q, amt_d;
  logic        mode_q, mode_d;
  logic        id_q, id_d;
  logic        grant_vld;
  logic        grant_id;

  assign grant_vld = req0_valid | req1_valid;

`ifdef SHIFT_ARB_RR_EN
  logic last_q, last_d;

  // On contention the requester that did not win last time is served.
  always_comb begin
    grant_id = req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  assign grant_id = ~req0_valid;
`endif

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    amt_d      = amt_q;
    mode_d     = mode_q;
    id_d       = id_q;
    result_d   = result_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
`ifdef SHIFT_ARB_RR_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        // Ready is combinational, so it is gated by reset to keep it low while reset is held.
        if (grant_vld && rst_n) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          data_d     = grant_id ? req1_data : req0_data;
          amt_d      = grant_id ? req1_amt  : req0_amt;
          mode_d     = grant_id ? req1_mode : req0_mode;
          id_d       = grant_id;
          state_d    = EXEC;
`ifdef SHIFT_ARB_RR_EN
          last_d     = grant_id;
`endif
        end
      end
      EXEC: begin
        result_d = shf_out;
        state_d  = RESP;
      end
      RESP: begin
        rsp0_valid = ~id_q;
        rsp1_valid = id_q;
        if (id_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      amt_q    <= '0;
      mode_q   <= 1'b0;
      id_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      amt_q    <= amt_d;
      mode_q   <= mode_d;
      id_q     <= id_d;
      result_q <= result_d;
    end
  end

  assign shf_in   = data_q;
  assign shf_val  = amt_q;
  assign shf_mode = mode_q;
  assign rsp_data = result_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: external shifter model, transaction-level reference model checked every cycle, directed and random traffic.
module tb_shift_arbiter;

`ifdef SHIFT_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_data = '0, req1_data = '0;
  logic [3:0]  req0_amt = '0, req1_amt = '0;
  logic        req0_mode = 1'b0, req1_mode = 1'b0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [15:0] rsp_data, shf_in, shf_out;
  logic [3:0]  shf_val;
  logic        shf_mode, busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int n_done = 0;

  shift_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_amt(req0_amt), .req1_amt(req1_amt),
    .req0_mode(req0_mode), .req1_mode(req1_mode),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data),
    .shf_in(shf_in), .shf_val(shf_val), .shf_mode(shf_mode),
    .shf_out(shf_out), .busy(busy)
  );

  // Shared combinational shifter
  logic signed [15:0] shf_signed;
  always_comb begin
    shf_signed = $signed(shf_in) >>> shf_val;
    shf_out    = shf_mode ? shf_signed : (shf_in << shf_val);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Arithmetic reference: multiply/wrap for left shifts, floor division for arithmetic right shifts.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] a, input logic m);
    longint p, v, q;
    p = longint'(1) << a;
    if (!m) return 16'((longint'(d) * p) % 65536);
    v = (d >= 16'h8000) ? longint'(d) - 65536 : longint'(d);
    q = v / p;
    if (v < 0 && (v % p) != 0) q = q - 1;
    return 16'(q);
  endfunction

  typedef struct packed {logic id; logic [15:0] dat;} obs_t;
  obs_t obs_q[$];

  logic        m_pend = 1'b0, m_owner = 1'b0, m_last = 1'b1, m_mode = 1'b0;
  logic [15:0] m_data = '0, m_res = '0;
  logic [3:0]  m_amt = '0;
  int          m_acc = 0;

  always @(negedge clk) begin
    int g;
    logic ev0, ev1;
    if (!rst_n) begin
      check("rst_busy", busy, 0);
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      check("rst_rsp0_valid", rsp0_valid, 0);
      check("rst_rsp1_valid", rsp1_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_shf_in", shf_in, 0);
      check("rst_shf_val", shf_val, 0);
      check("rst_shf_mode", shf_mode, 0);
      m_pend = 1'b0;
      m_last = 1'b1;
    end else begin
      g = -1;
      if (!m_pend) begin
        if (req0_valid && req1_valid) g = RR ? (m_last ? 0 : 1) : 0;
        else if (req0_valid) g = 0;
        else if (req1_valid) g = 1;
      end
      ev0 = m_pend && !m_owner && (cyc >= m_acc + 2);
      ev1 = m_pend &&  m_owner && (cyc >= m_acc + 2);
      check("busy", busy, m_pend);
      check("req0_ready", req0_ready, g == 0);
      check("req1_ready", req1_ready, g == 1);
      check("rsp0_valid", rsp0_valid, ev0);
      check("rsp1_valid", rsp1_valid, ev1);
      if (m_pend) begin
        check("shf_in", shf_in, m_data);
        check("shf_val", shf_val, m_amt);
        check("shf_mode", shf_mode, m_mode);
      end
      if (ev0 || ev1) check("rsp_data", rsp_data, m_res);
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))
        obs_q.push_back('{id: rsp1_valid, dat: rsp_data});
      if (g >= 0) begin
        m_pend  = 1'b1;
        m_owner = (g == 1);
        m_acc   = cyc;
        m_data  = m_owner ? req1_data : req0_data;
        m_amt   = m_owner ? req1_amt  : req0_amt;
        m_mode  = m_owner ? req1_mode : req0_mode;
        m_res   = ref_shift(m_data, m_amt, m_mode);
        m_last  = m_owner;
      end else if ((ev0 && rsp0_ready) || (ev1 && rsp1_ready)) begin
        m_pend = 1'b0;
        n_done++;
      end
    end
  end

  task automatic wait_grant(input bit n, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (n ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_grant"}, got, 1);
  endtask

  task automatic run_one(input bit n, input logic [15:0] d, input logic [3:0] a, input bit m,
                         input logic [15:0] exp, input string tag);
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    if (n) begin
      req1_valid = 1'b1; req1_data = d; req1_amt = a; req1_mode = m;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_amt = a; req0_mode = m;
    end
    wait_grant(n, tag);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check({tag, "_exec_busy"}, busy, 1);
    check({tag, "_exec_rsp_valid"}, {rsp1_valid, rsp0_valid}, 0);
    @(negedge clk);
    check({tag, "_rsp_own"}, n ? rsp1_valid : rsp0_valid, 1);
    check({tag, "_rsp_other"}, n ? rsp0_valid : rsp1_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, exp);
    @(negedge clk);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic        exp_id[3];
    logic [15:0] exp_dat[3];
    int          done0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_one(1'b0, 16'h8001, 4'd4, 1'b0, 16'h0010, "sll");
    run_one(1'b1, 16'h8000, 4'd3, 1'b1, 16'hF000, "sra");

    // Both requesters valid continuously
    obs_q.delete();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 16'h0001; req0_amt = 4'd1; req0_mode = 1'b0;
    req1_valid = 1'b1; req1_data = 16'h00F0; req1_amt = 4'd4; req1_mode = 1'b1;
    for (int i = 0; i < 40 && obs_q.size() < 3; i++) begin
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (RR) begin
      exp_id = '{1'b0, 1'b1, 1'b0};
      exp_dat = '{16'h0002, 16'h000F, 16'h0002};
    end else begin
      exp_id = '{1'b0, 1'b0, 1'b0};
      exp_dat = '{16'h0002, 16'h0002, 16'h0002};
    end
    check("arb_count", obs_q.size(), 3);
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      check("arb_id", obs_q[i].id, exp_id[i]);
      check("arb_data", obs_q[i].dat, exp_dat[i]);
    end
    repeat (4) @(posedge clk);

    run_one(1'b0, 16'hABCD, 4'd0, 1'b1, 16'hABCD, "amt0");
    run_one(1'b1, 16'h8000, 4'd15, 1'b1, 16'hFFFF, "sra15");
    run_one(1'b0, 16'hFFFF, 4'd15, 1'b0, 16'h8000, "sll15");
    run_one(1'b1, 16'h7FFF, 4'd1, 1'b1, 16'h3FFF, "sra_pos");

    // Response stalled for five cycles while requester 1 waits
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 16'h0003; req0_amt = 4'd2; req0_mode = 1'b0;
    wait_grant(1'b0, "hold");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 16'h0100; req1_amt = 4'd8; req1_mode = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rsp0_valid", rsp0_valid, 1);
      check("hold_rsp_data", rsp_data, 16'h000C);
      check("hold_req1_ready", req1_ready, 0);
      check("hold_busy", busy, 1);
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", rsp0_valid, 1);
    @(negedge clk);
    check("hold_next_grant", req1_ready, 1);
    check("hold_next_idle", busy, 0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("hold_rsp1_valid", rsp1_valid, 1);
    check("hold_rsp1_data", rsp_data, 16'h0001);

    // Reset pulse while the transaction is in EXEC
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 16'h1234; req0_amt = 4'd2; req0_mode = 1'b0;
    wait_grant(1'b0, "rst");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rsp0_valid", rsp0_valid, 0);
    check("rst_mid_rsp_data", rsp_data, 0);
    check("rst_mid_shf_in", shf_in, 0);
    check("rst_mid_shf_val", shf_val, 0);
    check("rst_mid_req0_ready", req0_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_after_rsp0_valid", rsp0_valid, 0);
      check("rst_after_busy", busy, 0);
    end

    // Random traffic on both requesters with occasional response stalls
    done0 = n_done;
    for (int c = 0; c < 60000 && (n_done - done0) < 10000; c++) begin
      @(posedge clk); #1;
      req0_valid = ($urandom_range(7) != 0);
      req1_valid = ($urandom_range(7) != 0);
      req0_data  = 16'($urandom);
      req1_data  = 16'($urandom);
      req0_amt   = 4'($urandom);
      req1_amt   = 4'($urandom);
      req0_mode  = 1'($urandom);
      req1_mode  = 1'($urandom);
      rsp0_ready = ($urandom_range(7) != 0);
      rsp1_ready = ($urandom_range(7) != 0);
    end
    check("rand_done", (n_done - done0) >= 10000, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
